// File: rtl/shift_seq_pkg.sv
// Shared opcodes, register mode codes and FSM state encoding for the
// shift_sequencer controller.
package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD_SHIFT = 2'b00;
  localparam logic [1:0] OP_ROTATE     = 2'b01;
  localparam logic [1:0] OP_SHIFT_ONLY = 2'b10;
  localparam logic [1:0] OP_NOP        = 2'b11;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_SHIFT  = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

endpackage

// File: rtl/registrodesplazable.sv
// 4-bit shift register with shift, rotate and parallel-load modes; S_OUT is
// the bit about to leave in the selected direction.
module registrodesplazable (
  input  logic       CLK,
  input  logic       ENB,
  input  logic       DIR,
  input  logic       S_IN,
  input  logic [1:0] MODO,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       S_OUT
);

  logic [3:0] q_q;

  always_ff @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        2'b00:   q_q <= DIR ? {S_IN, q_q[3:1]} : {q_q[2:0], S_IN};
        2'b01:   q_q <= DIR ? {q_q[0], q_q[3:1]} : {q_q[2:0], q_q[3]};
        2'b10:   q_q <= D;
        default: q_q <= q_q;
      endcase
    end
  end

  assign Q     = q_q;
  assign S_OUT = DIR ? q_q[0] : q_q[3];

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for registrodesplazable: accepts one command at a
// time, sequences load/shift cycles, captures S_OUT and reports the final Q.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int CAP_W = 8
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic [3:0]       CMD_DATA,
  input  logic             CMD_SIN,
  output logic             ENB,
  output logic             DIR,
  output logic             S_IN,
  output logic [1:0]       MODO,
  output logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             S_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       RESULT,
  output logic [CAP_W-1:0] CAP
);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               dir_q, dir_d;
  logic               sin_q, sin_d;
  logic [3:0]         data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CAP_W-1:0]   cap_q, cap_d;
  logic [3:0]         result_q, result_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dir_d    = dir_q;
    sin_d    = sin_q;
    data_d   = data_q;
    count_d  = count_q;
    cap_d    = cap_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          op_d    = CMD_OP;
          dir_d   = CMD_DIR;
          sin_d   = CMD_SIN;
          data_d  = CMD_DATA;
          count_d = CMD_COUNT;
          cap_d   = '0;
          case (CMD_OP)
            OP_LOAD_SHIFT: state_d = ST_LOAD;
            OP_ROTATE, OP_SHIFT_ONLY:
              state_d = (CMD_COUNT == '0) ? ST_FINISH : ST_SHIFT;
            default: state_d = ST_FINISH;
          endcase
        end
      end
      ST_LOAD: begin
        state_d = (count_q == '0) ? ST_FINISH : ST_SHIFT;
      end
      ST_SHIFT: begin
        // S_OUT here is the bit leaving the register at this edge.
        cap_d   = {cap_q[CAP_W-2:0], S_OUT};
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        result_d = Q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      dir_q    <= 1'b0;
      sin_q    <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
      cap_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dir_q    <= dir_d;
      sin_q    <= sin_d;
      data_q   <= data_d;
      count_q  <= count_d;
      cap_q    <= cap_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    ENB  = 1'b0;
    DIR  = 1'b0;
    S_IN = 1'b0;
    MODO = MODO_SHIFT;
    D    = '0;
    case (state_q)
      ST_LOAD: begin
        ENB  = 1'b1;
        MODO = MODO_LOAD;
        D    = data_q;
      end
      ST_SHIFT: begin
        ENB  = 1'b1;
        DIR  = dir_q;
        S_IN = sin_q;
        MODO = (op_q == OP_ROTATE) ? MODO_ROT : MODO_SHIFT;
      end
      default: ;
    endcase
  end

  // Ready is gated by reset so the host never sees a handshake while held in reset.
  assign CMD_READY = RST_N && (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign CAP       = cap_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: shift_sequencer driving registrodesplazable, with a
// behavioural register model feeding a scoreboard of expected completions.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int CNT_W = 4;
  localparam int CAP_W = 8;

  logic             clk = 1'b0;
  logic             RST_N;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic             CMD_DIR;
  logic [CNT_W-1:0] CMD_COUNT;
  logic [3:0]       CMD_DATA;
  logic             CMD_SIN;
  logic             ENB, DIR, S_IN;
  logic [1:0]       MODO;
  logic [3:0]       D;
  logic [3:0]       Q;
  logic             S_OUT;
  logic             BUSY, DONE;
  logic [3:0]       RESULT;
  logic [CAP_W-1:0] CAP;

  always #5 clk = ~clk;

  shift_sequencer #(.CNT_W(CNT_W), .CAP_W(CAP_W)) dut (
    .clk(clk), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_DIR(CMD_DIR), .CMD_COUNT(CMD_COUNT), .CMD_DATA(CMD_DATA),
    .CMD_SIN(CMD_SIN),
    .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D),
    .Q(Q), .S_OUT(S_OUT),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .CAP(CAP)
  );

  registrodesplazable reg_u (
    .CLK(clk), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D),
    .Q(Q), .S_OUT(S_OUT)
  );

  typedef struct {
    logic [3:0]       result;
    logic [CAP_W-1:0] cap;
    int               lat;
    int               enb_cycles;
    string            name;
  } exp_t;

  exp_t       sb_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [3:0] model_q = 4'b0000;

  function automatic exp_t model_cmd(input logic [1:0] op, input logic dir,
                                     input int count, input logic [3:0] data,
                                     input logic sin, input logic [3:0] q_in,
                                     input string name);
    exp_t e;
    logic [3:0] q;
    logic so;
    int steps;
    q = q_in;
    e.cap = '0;
    e.enb_cycles = 0;
    e.name = name;
    steps = 0;
    case (op)
      OP_LOAD_SHIFT: begin
        q = data;
        e.enb_cycles = 1;
        steps = count;
        e.lat = count + 2;
      end
      OP_ROTATE, OP_SHIFT_ONLY: begin
        steps = count;
        e.lat = (count == 0) ? 1 : count + 1;
      end
      default: e.lat = 1;
    endcase
    for (int i = 0; i < steps; i++) begin
      so = dir ? q[0] : q[3];
      e.cap = {e.cap[CAP_W-2:0], so};
      if (op == OP_ROTATE) q = dir ? {q[0], q[3:1]} : {q[2:0], q[3]};
      else                 q = dir ? {sin, q[3:1]} : {q[2:0], sin};
      e.enb_cycles++;
    end
    e.result = q;
    return e;
  endfunction

  task automatic push_cmd(input logic [1:0] op, input logic dir, input int count,
                          input logic [3:0] data, input logic sin, input string name);
    exp_t e;
    e = model_cmd(op, dir, count, data, sin, model_q, name);
    model_q = e.result;
    sb_q.push_back(e);
  endtask

  // Returns just after the accept edge; CMD_VALID is left high.
  task automatic issue_cmd(input logic [1:0] op, input logic dir, input int count,
                           input logic [3:0] data, input logic sin);
    @(negedge clk);
    CMD_OP    = op;
    CMD_DIR   = dir;
    CMD_COUNT = CNT_W'(count);
    CMD_DATA  = data;
    CMD_SIN   = sin;
    CMD_VALID = 1'b1;
    for (int i = 0; i < 64 && CMD_READY !== 1'b1; i++) @(negedge clk);
    tests_run++;
    if (CMD_READY !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL accept_timeout: CMD_READY=%b, required 1", CMD_READY);
    end
    @(posedge clk);
  endtask

  // Called right after an accept edge; waits for DONE and checks the popped expectation.
  task automatic wait_and_check();
    int k = 0;
    int enb_n = 0;
    int gap_bad = 0;
    bit seen = 0;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (DONE === 1'b1) begin
        seen = 1;
        break;
      end
      if (CMD_READY !== 1'b0 || BUSY !== 1'b1) gap_bad++;
      if (ENB === 1'b1) enb_n++;
      @(posedge clk);
      k++;
    end
    tests_run++;
    if (!seen || sb_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL done_timeout: seen=%0d queued=%0d, required DONE with a queued expectation",
               seen, sb_q.size());
      return;
    end
    e = sb_q.pop_front();
    tests_run++;
    if (RESULT !== e.result) begin
      tests_failed++;
      $display("[TB] FAIL %s result: got %b, expected %b", e.name, RESULT, e.result);
    end
    tests_run++;
    if (CAP !== e.cap) begin
      tests_failed++;
      $display("[TB] FAIL %s cap: got %b, expected %b", e.name, CAP, e.cap);
    end
    tests_run++;
    if (k != e.lat) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: DONE after E%0d, expected E%0d", e.name, k, e.lat);
    end
    tests_run++;
    if (enb_n != e.enb_cycles) begin
      tests_failed++;
      $display("[TB] FAIL %s enb_cycles: got %0d, expected %0d", e.name, enb_n, e.enb_cycles);
    end
    tests_run++;
    if (gap_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s busy_window: %0d cycles with READY/BUSY wrong, expected 0", e.name, gap_bad);
    end
    tests_run++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s done_cycle: READY=%b BUSY=%b, expected READY=1 BUSY=0",
               e.name, CMD_READY, BUSY);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic dir, input int count,
                         input logic [3:0] data, input logic sin, input string name);
    push_cmd(op, dir, count, data, sin, name);
    issue_cmd(op, dir, count, data, sin);
    #1 CMD_VALID = 1'b0;
    wait_and_check();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP = 2'b00; CMD_DIR = 1'b0; CMD_COUNT = '0; CMD_DATA = '0; CMD_SIN = 1'b0;
    #12;
    tests_run++;
    if ({ENB, BUSY, DONE, CMD_READY, DIR, S_IN} !== 6'b0 || MODO !== 2'b00 || D !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: ENB=%b BUSY=%b DONE=%b READY=%b DIR=%b S_IN=%b MODO=%b D=%b, expected all 0",
               ENB, BUSY, DONE, CMD_READY, DIR, S_IN, MODO, D);
    end
    tests_run++;
    if (CAP !== '0 || RESULT !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: CAP=%b RESULT=%b, expected 0", CAP, RESULT);
    end
    @(negedge clk) RST_N = 1'b1;
    @(negedge clk);
    tests_run++;
    if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: READY=%b BUSY=%b, expected READY=1 BUSY=0", CMD_READY, BUSY);
    end
  endtask

  task automatic test_load_shift();
    run_cmd(OP_LOAD_SHIFT, 1'b0, 2, 4'b1011, 1'b0, "load_shift");
  endtask

  task automatic test_rotate();
    run_cmd(OP_LOAD_SHIFT, 1'b0, 0, 4'b1011, 1'b0, "preload_1011");
    run_cmd(OP_ROTATE, 1'b1, 4, 4'b0000, 1'b0, "rotate_right4");
    run_cmd(OP_ROTATE, 1'b0, 0, 4'b0000, 1'b0, "rotate_zero");
  endtask

  task automatic test_back_to_back();
    push_cmd(OP_SHIFT_ONLY, 1'b1, 3, 4'b0000, 1'b1, "b2b_first");
    push_cmd(OP_ROTATE, 1'b0, 2, 4'b0000, 1'b0, "b2b_second");
    issue_cmd(OP_SHIFT_ONLY, 1'b1, 3, 4'b0000, 1'b1);
    #1;
    CMD_OP = OP_ROTATE; CMD_DIR = 1'b0; CMD_COUNT = CNT_W'(2); CMD_SIN = 1'b0;
    wait_and_check();
    @(posedge clk);
    #1 CMD_VALID = 1'b0;
    wait_and_check();
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    run_cmd(OP_LOAD_SHIFT, 1'b0, 0, 4'b1010, 1'b0, "preload_1010");
    issue_cmd(OP_SHIFT_ONLY, 1'b0, 5, 4'b0000, 1'b0);
    #1 CMD_VALID = 1'b0;
    @(posedge clk);
    #2 RST_N = 1'b0;
    #1;
    tests_run++;
    if (ENB !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CMD_READY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_ctrl: ENB=%b BUSY=%b DONE=%b READY=%b, expected all 0",
               ENB, BUSY, DONE, CMD_READY);
    end
    tests_run++;
    if (CAP !== '0 || RESULT !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_data: CAP=%b RESULT=%b, expected 0", CAP, RESULT);
    end
    model_q = {model_q[2:0], 1'b0};
    @(negedge clk);
    @(negedge clk) RST_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (DONE === 1'b1) done_seen++;
    end
    tests_run++;
    if (done_seen != 0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_nodone: DONE cycles=%0d BUSY=%b, expected 0 and 0", done_seen, BUSY);
    end
  endtask

  task automatic test_nop();
    run_cmd(OP_LOAD_SHIFT, 1'b0, 0, 4'b0110, 1'b0, "preload_0110");
    run_cmd(OP_NOP, 1'b1, 5, 4'b1111, 1'b1, "nop");
  endtask

  task automatic test_shift_only();
    run_cmd(OP_LOAD_SHIFT, 1'b0, 0, 4'b0000, 1'b0, "preload_0000");
    run_cmd(OP_SHIFT_ONLY, 1'b0, 10, 4'b0000, 1'b1, "shift_only10");
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_rotate();
    test_back_to_back();
    test_reset_mid();
    test_nop();
    test_shift_only();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
